// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
package fetch_pc_gen_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 2;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } fetch_state_t;

    // Every PC load is forced onto a 4-byte instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_hit_count.sv
// Counts consecutive non-missing slots starting at the PC offset within
// the current fetch block. Miss bits below the offset are don't-care.
module fetch_hit_count #(
    parameter  int unsigned FETCH_WIDTH = 4,
    localparam int unsigned CW          = $clog2(FETCH_WIDTH) + 1
) (
    input  logic [FETCH_WIDTH-1:0] i_cache_miss,
    input  logic [CW-1:0]          i_off,
    output logic [CW-1:0]          o_hit
);

    logic run;

    // Walk the slots from the offset upward, stopping at the first miss.
    always_comb begin
        o_hit = '0;
        run   = 1'b1;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (CW'(k) >= i_off) begin
                if (i_cache_miss[k]) begin
                    run = 1'b0;
                end else if (run) begin
                    o_hit = o_hit + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential advance within aligned fetch blocks,
// branch/flush redirects, post-flush bubble and halt handling.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter  int unsigned     FETCH_WIDTH  = 4,
    parameter  logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter  int unsigned     FLUSH_BUBBLE = 1,
    localparam int unsigned     CW           = $clog2(FETCH_WIDTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [FETCH_WIDTH-1:0] i_cache_miss,
    input  logic [CW-1:0]          i_di_count,
    input  logic                   i_halt,
    input  logic                   i_branch_en,
    input  logic [XLEN-1:0]        i_branch_target,
    input  logic                   i_flush_en,
    input  logic [XLEN-1:0]        i_flush_target,
    output logic [XLEN-1:0]        o_pc,
    output logic                   o_fetch_valid,
    output logic [FETCH_WIDTH-1:0] o_slot_mask,
    output logic                   o_redirect
);

    localparam logic [CNT_W-1:0] BUB_INIT = CNT_W'(FLUSH_BUBBLE);

    fetch_state_t     state_q, state_nxt;
    logic [XLEN-1:0]  pc_q, pc_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             redirect_q, redirect_nxt;

    logic [CW-1:0]    off;
    logic [CW-1:0]    avail;
    logic [CW-1:0]    hit;
    logic [CW-1:0]    consume;
    logic [XLEN-1:0]  advance;

    // Slot offset of the PC inside its aligned block (always 0 for 1-wide).
    if (FETCH_WIDTH == 1) begin : g_off_w1
        assign off = '0;
    end else begin : g_off_wn
        assign off = {1'b0, pc_q[$clog2(FETCH_WIDTH)+1:2]};
    end

    assign avail         = CW'(FETCH_WIDTH) - off;
    assign o_pc          = pc_q;
    assign o_redirect    = redirect_q;
    assign o_fetch_valid = (state_q == RUN) && !i_halt;

    fetch_hit_count #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_hit_count (
        .i_cache_miss (i_cache_miss),
        .i_off        (off),
        .o_hit        (hit)
    );

    // Slots at or beyond the PC offset are live in this block.
    always_comb begin
        o_slot_mask = '0;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            o_slot_mask[k] = (CW'(k) >= off);
        end
    end

    // Instructions retired from this block: bounded by hits, dispatch
    // acceptance and the block boundary, and zero when not fetching.
    always_comb begin
        consume = hit;
        if (i_di_count < consume) begin
            consume = i_di_count;
        end
        if (avail < consume) begin
            consume = avail;
        end
        if (!o_fetch_valid) begin
            consume = '0;
        end
        advance = {{(XLEN-CW-2){1'b0}}, consume, 2'b00};
    end

    // Next-state logic: flush beats branch beats sequential advance.
    always_comb begin
        state_nxt    = state_q;
        pc_nxt       = pc_q;
        cnt_nxt      = cnt_q;
        redirect_nxt = 1'b0;
        if (i_flush_en) begin
            pc_nxt       = align_pc(i_flush_target);
            redirect_nxt = 1'b1;
            if (FLUSH_BUBBLE == 0) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                state_nxt = BUBBLE;
                cnt_nxt   = BUB_INIT;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (i_halt) begin
                        state_nxt = HALT;
                    end else if (i_branch_en) begin
                        pc_nxt       = align_pc(i_branch_target);
                        redirect_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_q + advance;
                    end
                end
                BUBBLE: begin
                    // Counter is loaded with the bubble length, so the
                    // final bubble cycle is the one holding 1.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = i_halt ? HALT : RUN;
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end
                HALT: begin
                    if (!i_halt) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Architectural state register with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= align_pc(RESET_VECTOR);
            state_q    <= RUN;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_nxt;
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            redirect_q <= redirect_nxt;
        end
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 4, meaning instructions per fetch block; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the PC loaded on reset; must be 4-byte aligned.
REQ-003 SHALL have parameter FLUSH_BUBBLE, default 1, meaning fetch-invalid cycles after a flush redirect; legal range 0..3.
REQ-004 SHALL have the port i_clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-005 SHALL have the port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have the port i_cache_miss, input, FETCH_WIDTH bits: per-slot miss; bit k = slot k of the block.
REQ-007 SHALL have the port i_di_count, input, CW = clog2(FETCH_WIDTH)+1 bits: instructions accepted by dispatch this cycle.
REQ-008 SHALL have the port i_halt, input, 1 bit: hold the PC and drop fetch valid while asserted.
REQ-009 SHALL have the ports i_branch_en, input, 1 bit, and i_branch_target, input, 32 bits: predicted-taken redirect.
REQ-010 SHALL have the ports i_flush_en, input, 1 bit, and i_flush_target, input, 32 bits: mispredict/exception redirect.
REQ-011 SHALL have the port o_pc, output, 32 bits: current fetch PC.
REQ-012 SHALL have the port o_fetch_valid, output, 1 bit: o_pc is a valid fetch request this cycle.
REQ-013 SHALL have the port o_slot_mask, output, FETCH_WIDTH bits: slots at or after the PC offset within the aligned block.
REQ-014 SHALL have the port o_redirect, output, 1 bit: registered one-cycle pulse, the cycle after any accepted redirect.

Function
REQ-015 SHALL compute off = o_pc[clog2(FETCH_WIDTH)+1:2] and avail = FETCH_WIDTH - off; when FETCH_WIDTH=1, off = 0.
REQ-016 SHALL drive o_slot_mask bit k = (k >= off), combinationally.
REQ-017 SHALL set hit to the number of consecutive non-miss slots starting at slot off; miss bits below off are ignored.
REQ-018 SHALL compute consume = min(hit, i_di_count, avail); consume is 0 when o_fetch_valid=0.
REQ-019 SHALL, in state RUN with no redirect, load next_pc = o_pc + 4*consume, where consume=0 holds the PC.
REQ-020 SHALL cap each advance at the next aligned block boundary, so that no fetch crosses a block.
REQ-021 SHALL give redirects the priority flush > branch > sequential; a branch coincident with a flush is discarded.
REQ-022 SHALL have branch load i_branch_target next cycle, staying in RUN with o_fetch_valid=1; branch is ignored unless o_fetch_valid=1.
REQ-023 SHALL have flush load i_flush_target next cycle in any state, including HALT and BUBBLE.
REQ-024 SHALL, after a flush, enter BUBBLE for FLUSH_BUBBLE cycles, or RUN directly if the parameter is 0.
REQ-025 SHALL have the FSM states RUN, BUBBLE and HALT, with o_fetch_valid = (state==RUN) & ~i_halt.
REQ-026 SHALL go RUN->HALT when i_halt=1 and no flush; HALT->RUN when i_halt=0; the PC holds in HALT.
REQ-027 SHALL count down a 2-bit counter in BUBBLE, exiting to RUN at 0, or to HALT if i_halt=1.
REQ-028 SHALL restart the counter at FLUSH_BUBBLE when a flush arrives during BUBBLE.
REQ-029 SHALL force o_pc[1:0]=0 on every PC load, whether from redirect targets or reset.
REQ-030 SHALL wrap the PC modulo 2^32 with no error flag.

Reset
REQ-031 SHALL, on i_rst_n low, asynchronously set o_pc=RESET_VECTOR, state=RUN, counter=0 and o_redirect=0.
REQ-032 SHALL hold o_fetch_valid=1 from the first cycle after reset release unless i_halt=1.
REQ-033 SHALL let reset asserted mid-BUBBLE or mid-HALT abandon that state with no residual pulse.

Structure
REQ-034 SHALL put the state encoding fetch_state_t (RUN, BUBBLE, HALT) and the XLEN=32 constant in the shared package.
REQ-035 SHALL implement the slot-offset hit counting in one sub-module, fetch_hit_count (combinational, parametrised by FETCH_WIDTH).
REQ-036 SHALL register only o_pc, state, the counter and o_redirect; all other outputs are combinational from these and the inputs.

Verification
REQ-037 SHALL cover: W=4, pc=0x0, no miss, di_count=4 -> pc 0x10 next cycle, slot_mask=4'b1111.
REQ-038 SHALL cover: W=4, pc=0x8, no miss, di_count=4 -> consume 2, pc 0x10, slot_mask=4'b1100.
REQ-039 SHALL cover: W=4, pc=0x4, cache_miss=4'b0100 (slot 2), di_count=3 -> consume 1, pc 0x8.
REQ-040 SHALL cover: branch_en and flush_en together, targets 0x100 and 0x200 -> pc 0x200, redirect pulse 1 cycle, valid low 1 cycle (FLUSH_BUBBLE=1).
REQ-041 SHALL cover: flush to 0x40 during BUBBLE with FLUSH_BUBBLE=3 -> pc 0x40, 3 further invalid cycles.
REQ-042 SHALL cover: i_halt for 5 cycles, then reset mid-halt -> pc holds, then RESET_VECTOR, fetch valid the cycle after release.
